// File: rtl/kronos_clint_if.sv
// Data-bus responder interface for the kronos CLINT: request/ack handshake
// with byte-lane write mask and a registered read-data return.
interface kronos_clint_if;
  logic [31:0] data_addr;
  logic        data_req;
  logic        data_wr_en;
  logic [3:0]  data_mask;
  logic [31:0] data_wr_data;
  logic [31:0] data_rd_data;
  logic        data_ack;

  modport master (
    output data_addr, data_req, data_wr_en, data_mask, data_wr_data,
    input  data_rd_data, data_ack
  );

  modport slave (
    input  data_addr, data_req, data_wr_en, data_mask, data_wr_data,
    output data_rd_data, data_ack
  );
endinterface

// File: rtl/kronos_clint.sv
// Machine-level core-local interruptor: msip, mtime, mtimecmp behind a req/ack bus.
// Optional KRONOS_CLINT_SNAPSHOT_EN: mtime lo read latches hi into a shadow returned at 0xBFFC.
module kronos_clint #(
  parameter int unsigned TICK_DIV       = 1,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  kronos_clint_if.slave bus,
  output logic          software_interrupt,
  output logic          timer_interrupt,
  output logic [63:0]   mtime_out
);

  localparam int unsigned      PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, ACK} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [63:0]    mtime_q, mtime_d;
  logic [63:0]    mtimecmp_q, mtimecmp_d;
  logic           msip_q, msip_d;
  logic [31:0]    rd_data_q, rd_data_d;
  logic           timer_q;

  logic [13:0]    word;
  logic           commit, wr, rd, tick;
  logic           sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
  logic [31:0]    rdata;
  logic [31:0]    mtime_hi_rd;
  logic           unused_addr;

  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  assign word        = bus.data_addr[15:2];
  assign unused_addr = ^{bus.data_addr[31:16], bus.data_addr[1:0]};
  assign sel_msip    = (word == 14'h0000);
  assign sel_cmp_lo  = (word == 14'h1000);
  assign sel_cmp_hi  = (word == 14'h1001);
  assign sel_mt_lo   = (word == 14'h2FFE);
  assign sel_mt_hi   = (word == 14'h2FFF);

  assign commit = (state_q == IDLE) && bus.data_req;
  assign wr     = commit && bus.data_wr_en;
  assign rd     = commit && !bus.data_wr_en;
  assign tick   = (presc_q == PRESC_MAX);

`ifdef KRONOS_CLINT_SNAPSHOT_EN
  logic [31:0] shadow_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (rd && sel_mt_lo) begin
      shadow_q <= mtime_q[63:32];
    end
  end
  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    rdata = '0;
    if (sel_msip)   rdata = {31'b0, msip_q};
    if (sel_cmp_lo) rdata = mtimecmp_q[31:0];
    if (sel_cmp_hi) rdata = mtimecmp_q[63:32];
    if (sel_mt_lo)  rdata = mtime_q[31:0];
    if (sel_mt_hi)  rdata = mtime_hi_rd;
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rd_data_d  = rd_data_q;

    case (state_q)
      IDLE:    if (bus.data_req) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // mtime writes start from the un-incremented value, so a coincident tick is dropped entirely
    if (wr) begin
      if (sel_msip && bus.data_mask[0]) msip_d = bus.data_wr_data[0];
      if (sel_cmp_lo) mtimecmp_d[31:0]  = lane_merge(mtimecmp_q[31:0],  bus.data_wr_data, bus.data_mask);
      if (sel_cmp_hi) mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], bus.data_wr_data, bus.data_mask);
      if (sel_mt_lo)  mtime_d = {mtime_q[63:32], lane_merge(mtime_q[31:0], bus.data_wr_data, bus.data_mask)};
      if (sel_mt_hi)  mtime_d = {lane_merge(mtime_q[63:32], bus.data_wr_data, bus.data_mask), mtime_q[31:0]};
    end

    if (rd) rd_data_d = rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RESET;
      msip_q     <= 1'b0;
      rd_data_q  <= '0;
      timer_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rd_data_q  <= rd_data_d;
      timer_q    <= (mtime_q >= mtimecmp_q);
    end
  end

  assign bus.data_ack       = (state_q == ACK);
  assign bus.data_rd_data   = rd_data_q;
  assign software_interrupt = msip_q;
  assign timer_interrupt    = timer_q;
  assign mtime_out          = mtime_q;

endmodule

// File: tb/tb_kronos_clint.sv
// Scoreboard bench for kronos_clint: mtime is modelled as a closed-form function of
// the clock-edge count since reset and the last mtime write.
module tb_kronos_clint;

`ifdef KRONOS_CLINT_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kronos_clint_if bus();
  kronos_clint_if bus4();

  logic        sw_int, tmr_int, sw4, tmr4;
  logic [63:0] mt_out, mt_out4;

  kronos_clint #(.TICK_DIV(1), .MTIMECMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .software_interrupt(sw_int), .timer_interrupt(tmr_int), .mtime_out(mt_out)
  );

  kronos_clint #(.TICK_DIV(4), .MTIMECMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .software_interrupt(sw4), .timer_interrupt(tmr4), .mtime_out(mt_out4)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // clock edges since reset release
  int unsigned cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // reference model: mtime after edge n = value written at edge m_mtw plus ticks since then
  logic [63:0] m_mtv, m_cmp;
  int unsigned m_mtw;
  logic        m_msip;
  logic [31:0] m_shadow, m_lastrd;

  function automatic logic [63:0] mt_at(input int unsigned n);
    return m_mtv + 64'(n - m_mtw);
  endfunction

  function automatic logic [31:0] apply_mask(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] mask);
    logic [31:0] m;
    m = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    return (old & ~m) | (wd & m);
  endfunction

  task automatic reset_model();
    m_mtv = '0; m_mtw = 0; m_cmp = '1; m_msip = 1'b0; m_shadow = '0; m_lastrd = '0;
  endtask

  typedef struct {
    int unsigned edge_n;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
  exp_t q4[$];

  // one access on the TICK_DIV=1 instance; must be called at a negedge with the FSM idle
  task automatic access(input logic [31:0] addr, input logic wr, input logic [3:0] mask,
                        input logic [31:0] wd);
    exp_t        e;
    logic [15:0] off;
    logic [63:0] t, nv;
    int unsigned n;
    bit          seen;
    off      = addr[15:0] & 16'hFFFC;
    t        = mt_at(cyc);
    e.edge_n = cyc + 1;
    if (!wr) begin
      case (off)
        16'h0000: e.data = {31'b0, m_msip};
        16'h4000: e.data = m_cmp[31:0];
        16'h4004: e.data = m_cmp[63:32];
        16'hBFF8: e.data = t[31:0];
        16'hBFFC: e.data = SNAP ? m_shadow : t[63:32];
        default:  e.data = '0;
      endcase
      m_lastrd = e.data;
    end else begin
      e.data = m_lastrd;
    end
    q.push_back(e);
    bus.data_addr = addr; bus.data_wr_en = wr; bus.data_mask = mask;
    bus.data_wr_data = wd; bus.data_req = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    if (wr) begin
      case (off)
        16'h0000: if (mask[0]) m_msip = wd[0];
        16'h4000: m_cmp[31:0]  = apply_mask(m_cmp[31:0], wd, mask);
        16'h4004: m_cmp[63:32] = apply_mask(m_cmp[63:32], wd, mask);
        16'hBFF8: begin
          nv = mt_at(n - 1); nv[31:0] = apply_mask(nv[31:0], wd, mask);
          m_mtv = nv; m_mtw = n;
        end
        16'hBFFC: begin
          nv = mt_at(n - 1); nv[63:32] = apply_mask(nv[63:32], wd, mask);
          m_mtv = nv; m_mtw = n;
        end
        default: ;
      endcase
    end else if (off == 16'hBFF8) begin
      m_shadow = t[63:32];
    end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = bus.data_ack;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL ack_timeout: got no ack expected ack for addr %h", addr);
    end
    bus.data_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd4();
    exp_t e;
    bit   seen;
    e.edge_n = cyc + 1;
    e.data   = 32'(cyc / 4);
    q4.push_back(e);
    bus4.data_addr = 32'h0000_BFF8; bus4.data_wr_en = 1'b0; bus4.data_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = bus4.data_ack;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL ack4_timeout: got no ack expected ack");
    end
    bus4.data_req = 1'b0;
    @(negedge clk);
  endtask

  // scoreboard monitors
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ack = 1'b0;
    end else begin
      if (bus.data_ack) begin
        check("ack_width", {63'b0, prev_ack}, 64'd0);
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_ack: got ack expected none at edge %0d", cyc);
        end else begin
          e = q.pop_front();
          check("ack_edge", 64'(cyc), 64'(e.edge_n));
          check("rd_data", {32'b0, bus.data_rd_data}, {32'b0, e.data});
        end
      end
      prev_ack = bus.data_ack;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus4.data_ack) begin
      if (q4.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_ack4: got ack expected none at edge %0d", cyc);
      end else begin
        e = q4.pop_front();
        check("ack4_edge", 64'(cyc), 64'(e.edge_n));
        check("rd4_data", {32'b0, bus4.data_rd_data}, {32'b0, e.data});
      end
    end
  end

  // per-cycle interrupt and mtime checks; timer lags the compare by one edge
  logic exp_tmr = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_tmr = 1'b0;
    end else begin
      check("timer_int", {63'b0, tmr_int}, {63'b0, exp_tmr});
      check("sw_int", {63'b0, sw_int}, {63'b0, m_msip});
      check("mtime_out", mt_out, mt_at(cyc));
      check("mtime_out4", mt_out4, 64'(cyc / 4));
      exp_tmr = (mt_at(cyc) >= m_cmp);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, wd;
    logic [15:0] off;
    logic [3:0]  mask;
    logic        wr;
    int unsigned k;

    reset_model();
    bus.data_addr = '0; bus.data_req = 1'b0; bus.data_wr_en = 1'b0;
    bus.data_mask = '0; bus.data_wr_data = '0;
    bus4.data_addr = '0; bus4.data_req = 1'b0; bus4.data_wr_en = 1'b0;
    bus4.data_mask = '0; bus4.data_wr_data = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);

    repeat (10) @(negedge clk);
    access(32'h0000_BFF8, 1'b0, 4'h0, '0);
    rd4();

    // timer rise at mtime == 0x20, then fall after raising mtimecmp
    access(32'h0000_4004, 1'b1, 4'hF, 32'h0);
    access(32'h0000_4000, 1'b1, 4'hF, 32'h20);
    repeat (40) @(negedge clk);
    access(32'h0000_4000, 1'b1, 4'hF, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);

    // msip lane masking
    access(32'h0000_0000, 1'b1, 4'b0001, 32'hFFFF_FFFF);
    access(32'h0000_0000, 1'b0, 4'h0, '0);
    access(32'h0000_0000, 1'b1, 4'b0001, 32'h0);
    access(32'h0000_0000, 1'b1, 4'b1110, 32'h1);
    access(32'h0000_0000, 1'b0, 4'h0, '0);

    // full 64-bit wrap, then hi write coincident with a tick
    access(32'h0000_BFFC, 1'b1, 4'hF, 32'hFFFF_FFFF);
    access(32'h0000_BFF8, 1'b1, 4'hF, 32'hFFFF_FFFF);
    access(32'h0000_BFF8, 1'b0, 4'h0, '0);
    access(32'h0000_BFFC, 1'b0, 4'h0, '0);
    access(32'h0000_BFFC, 1'b1, 4'hF, 32'h1234_5678);
    access(32'h0000_BFF8, 1'b0, 4'h0, '0);
    access(32'h0000_BFFC, 1'b0, 4'h0, '0);

    // snapshot coherence across a lo->hi carry
    access(32'h0000_BFFC, 1'b1, 4'hF, 32'h0);
    access(32'h0000_BFF8, 1'b1, 4'hF, 32'hFFFF_FFFE);
    access(32'h0000_BFF8, 1'b0, 4'h0, '0);
    repeat (5) @(negedge clk);
    access(32'h0000_BFFC, 1'b0, 4'h0, '0);

    // unmapped offset
    access(32'h0000_1234, 1'b0, 4'h0, '0);
    access(32'h0000_1234, 1'b1, 4'hF, 32'hDEAD_BEEF);
    access(32'h0000_4000, 1'b0, 4'h0, '0);
    access(32'h0000_4004, 1'b0, 4'h0, '0);
    rd4();

    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      k = $urandom_range(0, 5);
      case (k)
        0: off = 16'h0000;
        1: off = 16'h4000;
        2: off = 16'h4004;
        3: off = 16'hBFF8;
        4: off = 16'hBFFC;
        default: begin
          off = r[15:0];
          if (off[15:2] == 14'h0000 || off[15:2] == 14'h1000 || off[15:2] == 14'h1001 ||
              off[15:2] == 14'h2FFE || off[15:2] == 14'h2FFF) off = 16'h1234;
        end
      endcase
      wr   = 1'($urandom_range(0, 1));
      mask = 4'($urandom);
      wd   = $urandom;
      access({r[31:16], off[15:2], r[1:0]}, wr, mask, wd);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i % 50 == 0) rd4();
    end

    // reset asserted while the ack is showing
    bus.data_addr = 32'h0000_0000; bus.data_wr_en = 1'b0; bus.data_req = 1'b1;
    @(posedge clk); #1;
    check("ack_before_rst", {63'b0, bus.data_ack}, 64'd1);
    rst = 1'b1;
    #1;
    check("ack_in_rst", {63'b0, bus.data_ack}, 64'd0);
    check("rd_data_in_rst", {32'b0, bus.data_rd_data}, 64'd0);
    bus.data_req = 1'b0;
    reset_model();
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    access(32'h0000_4000, 1'b0, 4'h0, '0);
    access(32'h0000_4004, 1'b0, 4'h0, '0);
    access(32'h0000_0000, 1'b0, 4'h0, '0);
    access(32'h0000_BFFC, 1'b0, 4'h0, '0);
    rd4();

    repeat (4) @(negedge clk);
    check("queue_drain", 64'(q.size()), 64'd0);
    check("queue4_drain", 64'(q4.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
